nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that slices 4·NIBBLES-bit operands into 4-bit nibbles.
- Feeds one nibble per clock, LSB nibble first, into an internal 4-bit carry-lookahead adder instance (CLA).
- Registers the CLA sum nibble and carry-out between cycles and presents the assembled wide result.
- Sits between the operand source and the result consumer; both sides use a valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set a/b/cin is valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry into nibble 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts the result
- sum  output  W  registered result
- cout  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; idx=0, carry register=0, operand registers=0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready is 1, but no capture occurs while rst_n is low.
- States:
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready, latch a, b and cin into the carry register, clear idx, go to RUN.
  - RUN: in_ready=0. Each edge:
    - The CLA computes a[idx], b[idx] plus the carry register.
    - Write the CLA sum into sum[4*idx+3:4*idx].
    - Carry register <= CLA cout; idx <= idx+1.
    - On the edge processing idx==NIBBLES-1: cout <= CLA cout, out_valid <= 1, go to DONE.
  - DONE: out_valid=1; sum and cout held stable. On an edge with out_ready high, out_valid <= 0 and state goes to IDLE.
- Latency:
  - Accept at edge k; out_valid is high after edge k+NIBBLES, i.e. exactly NIBBLES cycles.
  - Minimum spacing between accepts is NIBBLES+2 cycles.
- Output register timing:
  - sum is overwritten nibble by nibble during RUN and is only meaningful while out_valid=1.
  - sum is cleared to 0 on accept.
- Input stability: operands are sampled only at accept. Later changes on a, b or cin have no effect on an operation in flight.
- Backpressure: out_ready low in DONE holds out_valid, sum and cout indefinitely, with in_ready=0.
- Handshake rules:
  - out_ready may be high before out_valid; the result is taken on the first edge where both are high.
  - in_valid held high in RUN or DONE is ignored, not queued.
- Arithmetic:
  - Unsigned addition; {cout,sum} = a + b + cin, exactly W+1 bits.
  - Wrap-around is modulo 2^W with overflow reported only via cout.
- Reset mid-operation (RUN or DONE):
  - The in-flight result is discarded and out_valid drops asynchronously.
  - After rst_n deasserts, the block is in IDLE and accepts on the next in_valid.
- NIBBLES=1: RUN lasts one cycle; behaviour equals a registered single CLA.

Test Plan:
- a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x5555, cout=0; in_ready high again the cycle after the result handshake.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibble iterations). a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x00EC, b=0x00BA, cin=0 -> sum=0x01A6, cout=0. Nibble 0: 0xC+0xA gives 0x6 with carry 1. Nibble 1: 0xE+0xB+1 gives 0xA with carry 1. Nibble 2 absorbs the carry.
- Hold out_ready=0 for 6 cycles in DONE, toggling in_valid and a/b meanwhile -> sum/cout/out_valid unchanged, in_ready=0, no second accept. Raise out_ready -> one result handshake, then IDLE.
- Pulse rst_n low for half a cycle at idx=2 of an add of 0x8000+0x8000 -> out_valid, sum and cout read 0 immediately. The next add of 0x0F0F+0x00F1, cin=0, yields sum=0x1000, cout=0.
- Random back-to-back operations (≥1000, random in_valid/out_ready stalls) checked against the reference model a+b+cin for NIBBLES=4 and NIBBLES=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder : multi-cycle W-bit adder, one nibble per clock via CLA
// Revision 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p    = a_i ^ b_i;
  assign w_g    = a_i & b_i;
  assign w_c[0] = c_i;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign s_o    = w_p ^ w_c[3:0];
  assign c_o    = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            cout_q;
  logic            out_valid_q;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_cla_sum;
  logic            w_cla_cout;

  assign w_a_nib = a_q[4*idx_q +: 4];
  assign w_b_nib = b_q[4*idx_q +: 4];

  nibble_serial_adder_cla4 u_cla (
    .a_i (w_a_nib),
    .b_i (w_b_nib),
    .c_i (carry_q),
    .s_o (w_cla_sum),
    .c_o (w_cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Partial sum is visible here but only meaningful once out_valid rises.
          sum_q[4*idx_q +: 4] <= w_cla_sum;
          carry_q             <= w_cla_cout;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == C_LAST) begin
            cout_q      <= w_cla_cout;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

`default_nettype wire
